sysid_info_regs: RTL and testbench

//  Parametrised system-identification register file; successor to the 2-word SysID slave.

---
 rtl/sysid_info_regs.sv | 130 +++++++++++++
 tb/tb_sysid_info_regs.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sysid_info_regs.sv
// System-identification register file on an Avalon-MM slave: constant ID/version words,
// a byte-writable scratch word and a 64-bit uptime counter with tear-free hi/lo readout.
module sysid_info_regs #(
    parameter logic [31:0] SYSTEM_ID    = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
    parameter logic [31:0] VERSION      = 32'h0001_0000,
    parameter int unsigned CLK_FREQ_HZ  = 50_000_000,
    parameter logic [31:0] SCRATCH_RST  = 32'h0000_0000,
    parameter int unsigned ADDR_W       = 3,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              clock_i,
    input  logic              reset_n_i,
    input  logic [ADDR_W-1:0] address_i,
    input  logic              read_i,
    input  logic              write_i,
    input  logic [31:0]       writedata_i,
    input  logic [3:0]        byteenable_i,
    output logic [31:0]       readdata_o,
    output logic              readdatavalid_o
);

    localparam logic [ADDR_W-1:0] A_ID      = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_TS      = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_VER     = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_SCRATCH = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_UPLO    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_HISNAP  = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] A_CLKFREQ = ADDR_W'(6);
    localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(7);

    logic [31:0] scratch_q, scratch_d;
    logic [63:0] uptime_q, uptime_d;
    logic [31:0] hi_snap_q, hi_snap_d;
    logic        run_q, run_d;

    logic        rd_acc;
    logic        wr_scratch;
    logic        wr_ctrl;
    logic        clr;
    logic        snap;
    logic [31:0] rdata_mux;

    // A simultaneous write wins; the read is silently dropped.
    assign rd_acc     = read_i & ~write_i;
    assign wr_scratch = write_i & (address_i == A_SCRATCH);
    assign wr_ctrl    = write_i & (address_i == A_CTRL) & byteenable_i[0];
    assign clr        = wr_ctrl & writedata_i[1];
    assign snap       = rd_acc & (address_i == A_UPLO);

    always_comb begin
        scratch_d = scratch_q;
        for (int k = 0; k < 4; k++) begin
            if (wr_scratch && byteenable_i[k])
                scratch_d[8*k +: 8] = writedata_i[8*k +: 8];
        end
    end

    always_comb begin
        run_d     = wr_ctrl ? writedata_i[0] : run_q;
        hi_snap_d = snap ? uptime_q[63:32] : hi_snap_q;
        uptime_d  = uptime_q;
        if (clr)
            uptime_d = '0;
        else if (run_q)
            uptime_d = uptime_q + 64'd1;
    end

    always_comb begin
        rdata_mux = '0;
        case (address_i)
            A_ID:      rdata_mux = SYSTEM_ID;
            A_TS:      rdata_mux = TIMESTAMP;
            A_VER:     rdata_mux = VERSION;
            A_SCRATCH: rdata_mux = scratch_q;
            A_UPLO:    rdata_mux = uptime_q[31:0];
            A_HISNAP:  rdata_mux = hi_snap_q;
            A_CLKFREQ: rdata_mux = 32'(CLK_FREQ_HZ);
            A_CTRL:    rdata_mux = {31'd0, run_q};
            default:   rdata_mux = '0;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            scratch_q <= SCRATCH_RST;
            uptime_q  <= '0;
            hi_snap_q <= '0;
            run_q     <= 1'b1;
        end else begin
            scratch_q <= scratch_d;
            uptime_q  <= uptime_d;
            hi_snap_q <= hi_snap_d;
            run_q     <= run_d;
        end
    end

    // Read pipeline: stage 0 samples the register map at the accepting edge.
    // Data stages only load behind a valid, so the last stage holds its value.
    logic [READ_LATENCY-1:0]       vld_pipe_q;
    logic [READ_LATENCY-1:0][31:0] dat_pipe_q;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            vld_pipe_q[0] <= 1'b0;
            dat_pipe_q[0] <= '0;
        end else begin
            vld_pipe_q[0] <= rd_acc;
            if (rd_acc)
                dat_pipe_q[0] <= rdata_mux;
        end
    end

    for (genvar s = 1; s < READ_LATENCY; s++) begin : g_stage
        always_ff @(posedge clock_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                vld_pipe_q[s] <= 1'b0;
                dat_pipe_q[s] <= '0;
            end else begin
                vld_pipe_q[s] <= vld_pipe_q[s-1];
                if (vld_pipe_q[s-1])
                    dat_pipe_q[s] <= dat_pipe_q[s-1];
            end
        end
    end

    assign readdata_o      = dat_pipe_q[READ_LATENCY-1];
    assign readdatavalid_o = vld_pipe_q[READ_LATENCY-1];

endmodule

// File: tb/tb_sysid_info_regs.sv
// Directed bench for sysid_info_regs (ADDR_W=4, READ_LATENCY=2, non-zero scratch reset).
module tb_sysid_info_regs;

    localparam logic [31:0] P_ID   = 32'hC0DE_1D01;
    localparam logic [31:0] P_TS   = 32'h6612_3456;
    localparam logic [31:0] P_VER  = 32'h0002_0007;
    localparam int unsigned P_FREQ = 100_000_000;
    localparam logic [31:0] P_FREQ_W = 32'h05F5_E100;
    localparam logic [31:0] P_SRST = 32'h1234_5678;
    localparam int unsigned LAT    = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        readdatavalid;

    int tests = 0;
    int fails = 0;

    sysid_info_regs #(
        .SYSTEM_ID(P_ID), .TIMESTAMP(P_TS), .VERSION(P_VER), .CLK_FREQ_HZ(P_FREQ),
        .SCRATCH_RST(P_SRST), .ADDR_W(4), .READ_LATENCY(LAT)
    ) dut (
        .clock_i(clk), .reset_n_i(rst_n), .address_i(address), .read_i(read),
        .write_i(write), .writedata_i(writedata), .byteenable_i(byteenable),
        .readdata_o(readdata), .readdatavalid_o(readdatavalid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        address = a; writedata = d; byteenable = be; write = 1'b1;
        tick();
        write = 1'b0; byteenable = 4'h0;
    endtask

    // Accepts one read, then waits (bounded) for the strobe.
    task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
        int lat;
        address = a; read = 1'b1;
        tick();
        read = 1'b0;
        lat = 0;
        while (!readdatavalid && lat < 8) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(LAT - 1));
        chk(tag, readdata, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; address = '0; read = 1'b0; write = 1'b0;
        writedata = '0; byteenable = '0;
        repeat (3) tick();
        chk("rst_rdata", readdata, 32'h0);
        chk("rst_rdv", {31'd0, readdatavalid}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Back-to-back constant words
        address = 4'd0; read = 1'b1; tick();
        chk("t1_early", {31'd0, readdatavalid}, 32'h0);
        address = 4'd1; tick();
        chk("t1_v0", {31'd0, readdatavalid}, 32'h1); chk("t1_id", readdata, P_ID);
        address = 4'd2; tick();
        chk("t1_v1", {31'd0, readdatavalid}, 32'h1); chk("t1_ts", readdata, P_TS);
        address = 4'd6; tick();
        chk("t1_v2", {31'd0, readdatavalid}, 32'h1); chk("t1_ver", readdata, P_VER);
        read = 1'b0; tick();
        chk("t1_v3", {31'd0, readdatavalid}, 32'h1); chk("t1_freq", readdata, P_FREQ_W);
        tick();
        chk("t1_vdrop", {31'd0, readdatavalid}, 32'h0); chk("t1_hold", readdata, P_FREQ_W);

        // Reset values of RW/state words
        rd(4'd3, P_SRST, "rst_scratch");
        rd(4'd7, 32'h1, "rst_ctrl");
        rd(4'd5, 32'h0, "rst_hisnap");

        // Scratch byte lanes, out-of-range addresses
        wr(4'd3, 32'hDEAD_BEEF, 4'b0101);
        rd(4'd3, 32'h12AD_56EF, "t2_scratch");
        wr(4'd11, 32'hFFFF_FFFF, 4'hF);
        rd(4'd3, 32'h12AD_56EF, "oor_wr_ignored");
        rd(4'd9, 32'h0, "oor_rd");

        // Atomic readout across the carry
        force dut.uptime_q = 64'h0000_0001_FFFF_FFFF;
        address = 4'd4; read = 1'b1;
        tick();
        release dut.uptime_q;
        address = 4'd5;
        tick();
        read = 1'b0;
        chk("t3_lo_v", {31'd0, readdatavalid}, 32'h1); chk("t3_lo", readdata, 32'hFFFF_FFFF);
        tick();
        chk("t3_hi_v", {31'd0, readdatavalid}, 32'h1); chk("t3_hi", readdata, 32'h0000_0001);

        // RUN/CLR control; W = edge of the CTRL=3 write, read at edge N sees N-1-W
        wr(4'd7, 32'h3, 4'h1);
        rd(4'd4, 32'h0, "clr_run1_rd");
        rd(4'd4, 32'h2, "count_rd");
        wr(4'd7, 32'h0, 4'h1);
        repeat (10) tick();
        rd(4'd4, 32'h5, "stop_rd1");
        rd(4'd4, 32'h5, "stop_rd2");
        rd(4'd5, 32'h0, "stop_hi");
        wr(4'd7, 32'h3, 4'h1);
        rd(4'd4, 32'h0, "t4_clr_rd");
        rd(4'd4, 32'h2, "t4_count_rd");
        wr(4'd7, 32'h2, 4'h1);
        repeat (3) tick();
        rd(4'd4, 32'h0, "clr_run0_rd");
        rd(4'd7, 32'h0, "ctrl_run0");
        wr(4'd7, 32'h1, 4'b1110);
        rd(4'd7, 32'h0, "ctrl_be0_off");
        wr(4'd7, 32'hFFFF_FFFD, 4'hF);
        rd(4'd7, 32'h1, "ctrl_mask");

        // Reset during in-flight reads
        address = 4'd3; read = 1'b1;
        repeat (3) tick();
        read = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t5_rdv_now", {31'd0, readdatavalid}, 32'h0);
        chk("t5_rdata_now", readdata, 32'h0);
        tick();
        chk("t5_rdv_hold", {31'd0, readdatavalid}, 32'h0);
        rst_n = 1'b1;
        tick();
        chk("t5_rdv_after", {31'd0, readdatavalid}, 32'h0);
        chk("t5_rdata_after", readdata, 32'h0);
        rd(4'd3, P_SRST, "t5_scratch");
        rd(4'd7, 32'h1, "t5_ctrl");

        // Simultaneous read+write
        address = 4'd3; writedata = 32'hA5A5_A5A5; byteenable = 4'hF;
        write = 1'b1; read = 1'b1;
        tick();
        write = 1'b0; read = 1'b0; byteenable = 4'h0;
        for (int i = 0; i < 3; i++) begin
            chk("t6_no_rdv", {31'd0, readdatavalid}, 32'h0);
            tick();
        end
        rd(4'd3, 32'hA5A5_A5A5, "t6_scratch");
        wr(4'd0, 32'hFFFF_FFFF, 4'hF);
        rd(4'd0, P_ID, "t6_ro_id");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
